// File: rtl/seq_pkg.sv
// Shared sizes, transport state codes and the loop-wrap helper for the step sequencer.
package seq_pkg;
  localparam int unsigned STEPS     = 16;
  localparam int unsigned VOICES    = 8;
  localparam int unsigned STEP_W    = $clog2(STEPS);
  localparam int unsigned MIN_TICKS = 4;

  localparam logic [STEP_W:0] LOOP_MAX = STEPS[STEP_W:0];

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Step that follows cur for a requested loop length; 0 or oversize means full pattern.
  function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] cur,
                                                  input logic [STEP_W:0]   len);
    logic [STEP_W:0] eff;
    logic [STEP_W:0] inc;
    eff = ((len == '0) || (len > LOOP_MAX)) ? LOOP_MAX : len;
    inc = {1'b0, cur} + {{STEP_W{1'b0}}, 1'b1};
    return (inc >= eff) ? '0 : inc[STEP_W-1:0];
  endfunction
endpackage

// File: rtl/seq_port_arbiter.sv
// Pattern RAM port arbiter: playback fetch > editor > scan, with a scan anti-starvation override.
module seq_port_arbiter
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic play_i,
  input  logic ed_req_i,
  input  logic sc_req_i,
  output logic ed_gnt_o,
  output logic sc_gnt_o
);
  logic [1:0] streak_q;
  logic [1:0] streak_d;
  logic       sc_force;

  // Grant selection; nothing is granted while a playback fetch owns the port or in reset.
  always_comb begin
    sc_force = (streak_q == 2'd2) && sc_req_i;
    ed_gnt_o = 1'b0;
    sc_gnt_o = 1'b0;
    if (!rst && !play_i) begin
      if (sc_force)      sc_gnt_o = 1'b1;
      else if (ed_req_i) ed_gnt_o = 1'b1;
      else if (sc_req_i) sc_gnt_o = 1'b1;
    end
  end

  // Count editor wins that left a scan waiting; playback cycles leave the streak untouched.
  always_comb begin
    streak_d = streak_q;
    if (!play_i) begin
      if (ed_gnt_o && sc_req_i) streak_d = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;
      else                      streak_d = '0;
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
endmodule

// File: rtl/seq_step_scheduler.sv
// Transport FSM, step timer and next-row prefetch; owns and multiplexes the pattern RAM port.
module seq_step_scheduler
  import seq_pkg::*;
#(
  parameter int unsigned TICK_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic [TICK_W-1:0] step_ticks,
  input  logic [STEP_W:0]   loop_len,
  input  logic              ed_req,
  input  logic [STEP_W-1:0] ed_addr,
  input  logic [VOICES-1:0] ed_wdata,
  output logic              ed_gnt,
  input  logic              sc_req,
  input  logic [STEP_W-1:0] sc_addr,
  output logic              sc_gnt,
  output logic              sc_rvalid,
  output logic [VOICES-1:0] sc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [STEP_W-1:0] mem_addr,
  output logic [VOICES-1:0] mem_wdata,
  input  logic [VOICES-1:0] mem_rdata,
  output logic [STEP_W-1:0] step,
  output logic [VOICES-1:0] voice_en,
  output logic              step_strobe,
  output logic              playing
);
  localparam logic [TICK_W-1:0] MIN_P = TICK_W'(MIN_TICKS);

  logic [1:0]        state_q, state_d;
  logic              ld_ph_q, ld_ph_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [VOICES-1:0] voice_q, voice_d;
  logic              strobe_q, strobe_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W-1:0] period_q, period_d;
  logic [STEP_W-1:0] nxt_step_q, nxt_step_d;
  logic [VOICES-1:0] nxt_voice_q, nxt_voice_d;
  logic              pf_pend_q;
  logic              sc_rv_q;

  logic              play_fetch;
  logic [STEP_W-1:0] fetch_addr;
  logic [STEP_W-1:0] step_nx;
  logic [TICK_W-1:0] period_in;

  assign step_nx   = next_step(step_q, loop_len);
  assign period_in = (step_ticks < MIN_P) ? MIN_P : step_ticks;

  // Playback fetch: current row on the first LOAD cycle, next row three ticks before the boundary.
  always_comb begin
    play_fetch = 1'b0;
    fetch_addr = step_q;
    if ((state_q == ST_LOAD) && !ld_ph_q) begin
      play_fetch = 1'b1;
    end else if ((state_q == ST_RUN) && (tick_q == period_q - TICK_W'(3))) begin
      play_fetch = 1'b1;
      fetch_addr = step_nx;
    end
    if (rst) play_fetch = 1'b0;
  end

  seq_port_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .play_i   (play_fetch),
    .ed_req_i (ed_req),
    .sc_req_i (sc_req),
    .ed_gnt_o (ed_gnt),
    .sc_gnt_o (sc_gnt)
  );

  assign mem_en    = play_fetch | ed_gnt | sc_gnt;
  assign mem_we    = ed_gnt;
  assign mem_addr  = play_fetch ? fetch_addr : (ed_gnt ? ed_addr : (sc_gnt ? sc_addr : '0));
  assign mem_wdata = ed_gnt ? ed_wdata : '0;

  // Transport FSM and step timer; stop_req has priority over play_req everywhere.
  always_comb begin
    state_d     = state_q;
    ld_ph_d     = ld_ph_q;
    step_d      = step_q;
    voice_d     = voice_q;
    strobe_d    = 1'b0;
    tick_d      = tick_q;
    period_d    = period_q;
    nxt_step_d  = nxt_step_q;
    nxt_voice_d = nxt_voice_q;
    // The row address is captured with the fetch so the boundary uses exactly what was read.
    if (play_fetch && (state_q == ST_RUN)) nxt_step_d = step_nx;
    if (pf_pend_q) nxt_voice_d = mem_rdata;
    case (state_q)
      ST_STOP: begin
        if (play_req && !stop_req) begin
          state_d = ST_LOAD;
          ld_ph_d = 1'b0;
          step_d  = '0;
        end
      end
      ST_LOAD: begin
        if (!ld_ph_q) begin
          ld_ph_d = 1'b1;
        end else begin
          ld_ph_d  = 1'b0;
          voice_d  = mem_rdata;
          strobe_d = 1'b1;
          tick_d   = '0;
          period_d = period_in;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_HOLD;
          tick_d  = '0;
        end else if (tick_q == period_q - TICK_W'(1)) begin
          step_d   = nxt_step_q;
          voice_d  = nxt_voice_q;
          strobe_d = 1'b1;
          tick_d   = '0;
          period_d = period_in;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_HOLD: begin
        if (stop_req) begin
          state_d = ST_STOP;
          step_d  = '0;
          voice_d = '0;
        end else if (play_req) begin
          state_d = ST_LOAD;
          ld_ph_d = 1'b0;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // State registers; reset also drops any in-flight fetch or scan read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      ld_ph_q     <= 1'b0;
      step_q      <= '0;
      voice_q     <= '0;
      strobe_q    <= 1'b0;
      tick_q      <= '0;
      period_q    <= MIN_P;
      nxt_step_q  <= '0;
      nxt_voice_q <= '0;
      pf_pend_q   <= 1'b0;
      sc_rv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ph_q     <= ld_ph_d;
      step_q      <= step_d;
      voice_q     <= voice_d;
      strobe_q    <= strobe_d;
      tick_q      <= tick_d;
      period_q    <= period_d;
      nxt_step_q  <= nxt_step_d;
      nxt_voice_q <= nxt_voice_d;
      pf_pend_q   <= play_fetch;
      sc_rv_q     <= sc_gnt;
    end
  end

  assign sc_rvalid   = sc_rv_q;
  assign sc_rdata    = sc_rv_q ? mem_rdata : '0;
  assign step        = step_q;
  assign voice_en    = voice_q;
  assign step_strobe = strobe_q;
  assign playing     = (state_q == ST_LOAD) || (state_q == ST_RUN);
endmodule

// File: tb/tb_seq_step_scheduler.sv
// Randomized bench for seq_step_scheduler against a timeline/arbitration reference model.
module tb_seq_step_scheduler;
  import seq_pkg::*;

  localparam int unsigned TW = 25;

  typedef enum {M_STOP, M_LOAD, M_RUN, M_HOLD} mode_e;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              play_req = 1'b0, stop_req = 1'b0;
  logic [TW-1:0]     step_ticks = '0;
  logic [STEP_W:0]   loop_len = '0;
  logic              ed_req = 1'b0, ed_gnt;
  logic [STEP_W-1:0] ed_addr = '0;
  logic [VOICES-1:0] ed_wdata = '0;
  logic              sc_req = 1'b0, sc_gnt, sc_rvalid;
  logic [STEP_W-1:0] sc_addr = '0;
  logic [VOICES-1:0] sc_rdata;
  logic              mem_en, mem_we;
  logic [STEP_W-1:0] mem_addr;
  logic [VOICES-1:0] mem_wdata, mem_rdata;
  logic [STEP_W-1:0] step;
  logic [VOICES-1:0] voice_en;
  logic              step_strobe, playing;

  always #5 clk = ~clk;

  seq_step_scheduler #(.TICK_W(TW)) dut (
    .clk(clk), .rst(rst), .play_req(play_req), .stop_req(stop_req),
    .step_ticks(step_ticks), .loop_len(loop_len),
    .ed_req(ed_req), .ed_addr(ed_addr), .ed_wdata(ed_wdata), .ed_gnt(ed_gnt),
    .sc_req(sc_req), .sc_addr(sc_addr), .sc_gnt(sc_gnt), .sc_rvalid(sc_rvalid), .sc_rdata(sc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .step(step), .voice_en(voice_en), .step_strobe(step_strobe), .playing(playing)
  );

  // Pattern RAM with 1-cycle read latency plus a bench preload port.
  logic [VOICES-1:0] ram [STEPS];
  logic [VOICES-1:0] ram_q = '0;
  logic              pre_we = 1'b0;
  logic [STEP_W-1:0] pre_addr = '0;
  logic [VOICES-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [VOICES-1:0] ref_ram [STEPS];
  mode_e             mode = M_STOP;
  int                t_first = 0, P = 4, L = 16, ed_run = 0;
  logic [STEP_W-1:0] e_step = '0, pend_step = '0;
  logic [VOICES-1:0] e_voice = '0, pend_voice = '0;
  bit                ed_pend = 0, sc_pend = 0, rv_exp = 0;
  logic [STEP_W-1:0] ed_a = '0, sc_a = '0;
  logic [VOICES-1:0] ed_d = '0, rv_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [STEP_W-1:0] next_of(input logic [STEP_W-1:0] s);
    int n;
    n = int'(s) + 1;
    return (n >= L) ? '0 : STEP_W'(n);
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; play_req = 1'b0; stop_req = 1'b0; ed_req = 1'b0; sc_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_step",    32'(step), 32'(0));
    check_eq("rst_voice",   32'(voice_en), 32'(0));
    check_eq("rst_strobe",  32'(step_strobe), 32'(0));
    check_eq("rst_playing", 32'(playing), 32'(0));
    check_eq("rst_ed_gnt",  32'(ed_gnt), 32'(0));
    check_eq("rst_sc_gnt",  32'(sc_gnt), 32'(0));
    check_eq("rst_rvalid",  32'(sc_rvalid), 32'(0));
    check_eq("rst_rdata",   32'(sc_rdata), 32'(0));
    check_eq("rst_mem_en",  32'(mem_en), 32'(0));
    check_eq("rst_mem_we",  32'(mem_we), 32'(0));
    mode = M_STOP; e_step = '0; e_voice = '0; ed_run = 0;
    ed_pend = 0; sc_pend = 0; rv_exp = 0;
  endtask

  task automatic preload(input bit directed);
    for (int unsigned i = 0; i < STEPS; i++) begin
      logic [VOICES-1:0] v;
      v = VOICES'($urandom);
      if (directed && i < 4) v = VOICES'(1 << i);
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = STEP_W'(i); pre_data = v;
      ref_ram[i] = v;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One clock of stimulus, model evaluation and comparison.
  task automatic run_cycle(input bit pl, input bit st, input int unsigned req_pct);
    bit                fetch_e, strobe_e, ed_w, sc_w;
    logic [STEP_W-1:0] fetch_a;
    int                d;
    @(posedge clk); #1;
    if (!ed_pend && $urandom_range(99) < req_pct) begin
      ed_pend = 1; ed_a = STEP_W'($urandom); ed_d = VOICES'($urandom);
    end
    if (!sc_pend && $urandom_range(99) < req_pct) begin
      sc_pend = 1; sc_a = STEP_W'($urandom);
    end
    ed_req = ed_pend; ed_addr = ed_a; ed_wdata = ed_d;
    sc_req = sc_pend; sc_addr = sc_a;
    play_req = pl; stop_req = st;
    #1;
    fetch_e = 0; strobe_e = 0; fetch_a = '0;
    if (mode == M_LOAD && cyc == t_first - 2) begin
      fetch_e = 1; fetch_a = e_step; pend_step = e_step; pend_voice = ref_ram[e_step];
    end
    if (mode == M_LOAD && cyc == t_first) mode = M_RUN;
    if (mode == M_RUN) begin
      d = cyc - t_first;
      if (d % P == 0) begin
        strobe_e = 1; e_step = pend_step; e_voice = pend_voice;
      end
      if (d % P == P - 3) begin
        fetch_e = 1; fetch_a = next_of(e_step);
        pend_step = fetch_a; pend_voice = ref_ram[fetch_a];
      end
    end
    ed_w = 0; sc_w = 0;
    if (!fetch_e) begin
      if (sc_pend && (ed_run >= 2 || !ed_pend)) sc_w = 1;
      else if (ed_pend) ed_w = 1;
      ed_run = (ed_w && sc_pend) ? ed_run + 1 : 0;
    end
    check_eq("playing", 32'(playing), 32'(mode == M_LOAD || mode == M_RUN));
    check_eq("strobe",  32'(step_strobe), 32'(strobe_e));
    check_eq("step",    32'(step), 32'(e_step));
    check_eq("voice",   32'(voice_en), 32'(e_voice));
    check_eq("ed_gnt",  32'(ed_gnt), 32'(ed_w));
    check_eq("sc_gnt",  32'(sc_gnt), 32'(sc_w));
    check_eq("mem_en",  32'(mem_en), 32'(fetch_e | ed_w | sc_w));
    check_eq("mem_we",  32'(mem_we), 32'(ed_w));
    if (fetch_e) check_eq("fetch_addr", 32'(mem_addr), 32'(fetch_a));
    if (ed_w) begin
      check_eq("ed_addr",  32'(mem_addr), 32'(ed_a));
      check_eq("ed_wdata", 32'(mem_wdata), 32'(ed_d));
    end
    if (sc_w) check_eq("sc_addr", 32'(mem_addr), 32'(sc_a));
    check_eq("sc_rvalid", 32'(sc_rvalid), 32'(rv_exp));
    if (rv_exp) check_eq("sc_rdata", 32'(sc_rdata), 32'(rv_data));
    rv_exp = sc_w;
    if (sc_w) begin rv_data = ref_ram[sc_a]; sc_pend = 0; end
    if (ed_w) begin ref_ram[ed_a] = ed_d; ed_pend = 0; end
    case (mode)
      M_STOP: if (pl && !st) begin
        mode = M_LOAD; t_first = cyc + 3; e_step = '0;
        P = (int'(step_ticks) < 4) ? 4 : int'(step_ticks);
        L = (loop_len == 0 || int'(loop_len) > 16) ? 16 : int'(loop_len);
      end
      M_RUN: if (st) mode = M_HOLD;
      M_HOLD: if (st) begin
        mode = M_STOP; e_step = '0; e_voice = '0;
      end else if (pl) begin
        mode = M_LOAD; t_first = cyc + 3;
      end
      default: ;
    endcase
  endtask

  initial begin
    apply_reset();
    preload(1'b1);
    // Directed playback: period 8, four-step loop, hold/resume, then stop to STOP
    step_ticks = TW'(8); loop_len = 5'd4;
    run_cycle(1, 0, 0);
    repeat (42) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    repeat (6) run_cycle(0, 0, 0);
    run_cycle(1, 0, 0);
    repeat (20) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    repeat (3) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    repeat (3) run_cycle(0, 0, 0);
    // Editor and scan held continuously, idle then under playback
    repeat (30) run_cycle(0, 0, 100);
    run_cycle(1, 0, 100);
    repeat (60) run_cycle(0, 0, 100);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 0);
    repeat (4) run_cycle(0, 0, 0);
    // Short period clamps to the minimum; loop_len 0 plays all rows
    step_ticks = TW'(2); loop_len = 5'd0;
    run_cycle(1, 0, 0);
    repeat (70) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 0);
    // play and stop together in STOP is a stop
    run_cycle(1, 1, 0);
    repeat (3) run_cycle(0, 0, 0);
    // Reset during LOAD
    run_cycle(1, 0, 0);
    apply_reset();
    // Randomized sessions
    repeat (40) begin
      step_ticks = TW'($urandom_range(0, 9));
      loop_len   = 5'($urandom_range(0, 31));
      run_cycle(1, 0, 30);
      repeat ($urandom_range(20, 120)) begin
        bit pl, st;
        pl = ($urandom_range(99) < 5);
        st = ($urandom_range(99) < 5);
        if (mode == M_LOAD) begin pl = 0; st = 0; end
        run_cycle(pl, st, 30);
      end
      for (int i = 0; i < 10 && mode != M_STOP; i++) run_cycle(0, mode != M_LOAD, 30);
      check_eq("back_to_stop", 32'(mode == M_STOP), 32'(1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
